// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - FSM state type, default widths and window element-index helper for conv_mem_reader
package conv_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} conv_state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_IMG_W  = 4;
  localparam int DEF_IMG_H  = 4;
  localparam int DEF_K      = 3;
  localparam int DEF_STRIDE = 1;
  localparam int DEF_BASE   = 0;
  localparam int POS_W      = 16;

  function automatic int elem_idx(input int i, input int j, input int k);
    return i * k + j;
  endfunction

endpackage

// File: rtl/conv_win_shreg.sv
// rtl/conv_win_shreg.sv - KxK window register with indexed write and per-row left shift by STRIDE
module conv_win_shreg
  import conv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int K      = DEF_K,
  parameter int STRIDE = DEF_STRIDE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       shift,
  input  logic                       wr_en,
  input  logic [$clog2(K*K)-1:0]     wr_idx,
  input  logic [DATA_W-1:0]          wr_data,
  output logic [K*K*DATA_W-1:0]      win
);

  logic [DATA_W-1:0] elem [K*K];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < K * K; n++) elem[n] <= '0;
    end else begin
      // Shift precedes any write of the same fetch, so the two never collide
      if (shift) begin
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K - STRIDE; j++)
            elem[elem_idx(i, j, K)] <= elem[elem_idx(i, j + STRIDE, K)];
      end
      if (wr_en) elem[wr_idx] <= wr_data;
    end
  end

  for (genvar n = 0; n < K * K; n++) begin : g_flat
    assign win[n*DATA_W +: DATA_W] = elem[n];
  end

endmodule

// File: rtl/conv_mem_reader.sv
// rtl/conv_mem_reader.sv - KxK window fetch responder for the conv datapath; CONV_RD_REUSE_EN enables column reuse
module conv_mem_reader
  import conv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int K      = DEF_K,
  parameter int STRIDE = DEF_STRIDE,
  parameter int BASE   = DEF_BASE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  mem_rd,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_data,
  output logic [K*K*DATA_W-1:0] win_data,
  output logic                  done,
  output logic                  last_win
);

  localparam int CW = $clog2(K + 1);
  localparam int EW = $clog2(K * K);

  conv_state_e       state, state_n;
  logic [POS_W-1:0]  row, col;
  logic [CW-1:0]     rd_i, rd_j, cp_i, cp_j, iss_i, iss_j, j0;
  logic              rd_d, last_q, issue, fetch_go, reuse, col_wrap, row_wrap;
  logic [ADDR_W-1:0] addr_n;
  logic [EW-1:0]     wr_idx;

`ifdef CONV_RD_REUSE_EN
  assign reuse = (col != '0);
`else
  assign reuse = 1'b0;
`endif
  // Reuse fetches only the trailing STRIDE columns of each row
  assign j0 = reuse ? CW'(K - STRIDE) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    issue    = 1'b0;
    fetch_go = 1'b0;
    iss_i    = rd_i;
    iss_j    = rd_j;
    case (state)
      IDLE: if (start) begin
        state_n  = ISSUE;
        issue    = 1'b1;
        fetch_go = 1'b1;
        iss_i    = '0;
        iss_j    = j0;
      end
      ISSUE:   if (last_q) state_n = DRAIN; else issue = 1'b1;
      DRAIN:   state_n = DONE;
      DONE:    if (!start) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign done   = (state == DONE);
  assign addr_n = ADDR_W'(BASE) + ADDR_W'(row + POS_W'(iss_i)) * ADDR_W'(IMG_W)
                + ADDR_W'(col) + ADDR_W'(iss_j);
  assign wr_idx = EW'(elem_idx(int'(cp_i), int'(cp_j), K));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      last_q   <= 1'b0;
      rd_d     <= 1'b0;
      rd_i     <= '0;
      rd_j     <= '0;
      cp_i     <= '0;
      cp_j     <= '0;
    end else begin
      rd_d   <= mem_rd;
      mem_rd <= issue;
      if (issue) begin
        mem_addr <= addr_n;
        last_q   <= (iss_i == CW'(K - 1)) && (iss_j == CW'(K - 1));
        if (iss_j == CW'(K - 1)) begin
          rd_j <= j0;
          rd_i <= iss_i + CW'(1);
        end else begin
          rd_j <= iss_j + CW'(1);
          rd_i <= iss_i;
        end
      end
      // Memory returns data one cycle after the strobe, so captures trail reads by one
      if (fetch_go) begin
        cp_i <= '0;
        cp_j <= j0;
      end else if (rd_d) begin
        if (cp_j == CW'(K - 1)) begin
          cp_j <= j0;
          cp_i <= cp_i + CW'(1);
        end else begin
          cp_j <= cp_j + CW'(1);
        end
      end
    end
  end

  assign col_wrap = (col + POS_W'(STRIDE)) > POS_W'(IMG_W - K);
  assign row_wrap = (row + POS_W'(STRIDE)) > POS_W'(IMG_H - K);
  assign last_win = col_wrap && row_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (state == DONE && !start) begin
      if (col_wrap) begin
        col <= '0;
        row <= row_wrap ? '0 : row + POS_W'(STRIDE);
      end else begin
        col <= col + POS_W'(STRIDE);
      end
    end
  end

  conv_win_shreg #(
    .DATA_W (DATA_W),
    .K      (K),
    .STRIDE (STRIDE)
  ) u_win (
    .clk     (clk),
    .rst     (rst),
    .shift   (fetch_go && reuse),
    .wr_en   (rd_d),
    .wr_idx  (wr_idx),
    .wr_data (mem_data),
    .win     (win_data)
  );

endmodule

// File: tb/tb_conv_mem_reader.sv
// tb/tb_conv_mem_reader.sv - directed self-checking bench for conv_mem_reader (4x4 image, K=3, STRIDE=1)
module tb_conv_mem_reader;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int K      = 3;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic                  mem_rd;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_data = '0;
  logic [K*K*DATA_W-1:0] win_data;
  logic                  done;
  logic                  last_win;

  int vectors = 0;
  int errors  = 0;

  conv_mem_reader #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .IMG_W  (4),
    .IMG_H  (4),
    .K      (K),
    .STRIDE (1),
    .BASE   (0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .win_data (win_data),
    .done     (done),
    .last_win (last_win)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory preloaded with mem[a] = a
  always @(posedge clk) if (mem_rd) mem_data <= mem_addr;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input string tag, input int ea[9], input int n, input int ew[9],
                       input int cyc_exp, input logic exp_last, input int hold);
    int  got[$];
    int  cyc;
    bit  seen;
    cyc  = -1;
    seen = 0;
    @(posedge clk);
    #1 start = 1'b1;
    for (int c = 0; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (mem_rd) got.push_back(int'(mem_addr));
      if (done) begin
        seen = 1;
        cyc  = c;
      end
    end
    chk({tag, "_done_seen"}, 96'(seen), 96'(1));
    chk({tag, "_done_cycle"}, 96'(cyc), 96'(cyc_exp));
    chk({tag, "_rd_count"}, 96'(got.size()), 96'(n));
    for (int k = 0; k < n; k++)
      chk($sformatf("%s_addr%0d", tag, k), 96'(k < got.size() ? got[k] : -1), 96'(ea[k]));
    for (int k = 0; k < K * K; k++)
      chk($sformatf("%s_win%0d", tag, k), 96'(win_data[k*DATA_W +: DATA_W]), 96'(ew[k]));
    chk({tag, "_last_win"}, 96'(last_win), 96'(exp_last));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk($sformatf("%s_hold_done%0d", tag, h), 96'(done), 96'(1));
      chk($sformatf("%s_hold_rd%0d", tag, h), 96'(mem_rd), 96'(0));
    end
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk({tag, "_done_before_drop"}, 96'(done), 96'(1));
    @(negedge clk);
    chk({tag, "_done_after_drop"}, 96'(done), 96'(0));
  endtask

  initial begin
    int ea[9];
    int ew[9];

    repeat (2) @(negedge clk);
    chk("rst_done", 96'(done), 96'(0));
    chk("rst_mem_rd", 96'(mem_rd), 96'(0));
    chk("rst_mem_addr", 96'(mem_addr), 96'(0));
    chk("rst_win", 96'(win_data), 96'(0));
    chk("rst_last_win", 96'(last_win), 96'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    ea = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    fetch("f1", ea, 9, ea, 11, 1'b0, 5);

`ifdef CONV_RD_REUSE_EN
    ea = '{3, 7, 11, 0, 0, 0, 0, 0, 0};
    ew = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    fetch("f2", ea, 3, ew, 5, 1'b0, 0);
`else
    ea = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    fetch("f2", ea, 9, ea, 11, 1'b0, 0);
`endif

    ea = '{4, 5, 6, 8, 9, 10, 12, 13, 14};
    fetch("f3", ea, 9, ea, 11, 1'b0, 0);

`ifdef CONV_RD_REUSE_EN
    ea = '{7, 11, 15, 0, 0, 0, 0, 0, 0};
    ew = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
    fetch("f4", ea, 3, ew, 5, 1'b1, 0);
`else
    ea = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
    fetch("f4", ea, 9, ea, 11, 1'b1, 0);
`endif

    ea = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    fetch("f5", ea, 9, ea, 11, 1'b0, 0);

    // Abort a fetch in its 4th ISSUE cycle with an asynchronous reset
    @(posedge clk);
    #1 start = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_rd_active", 96'(mem_rd), 96'(1));
    rst = 1'b1;
    #1;
    chk("abort_mem_rd", 96'(mem_rd), 96'(0));
    chk("abort_done", 96'(done), 96'(0));
    chk("abort_win", 96'(win_data), 96'(0));
    start = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_idle_done", 96'(done), 96'(0));
    chk("abort_idle_rd", 96'(mem_rd), 96'(0));

    ea = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    fetch("f6", ea, 9, ea, 11, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
